// File: rtl/opensocdebug.sv
// Shared types for the core trace module: the mor1kx retired-instruction trace
// port and the call/return event record carried through the CTM event buffer.
package opensocdebug;

  // Only the trace fields the event classifier consumes are carried here.
  typedef struct packed {
    logic [31:0] pc;
    logic        jb;
    logic        jal;
    logic        jr;
    logic [31:0] jbtarget;
    logic        valid;
  } mor1kx_trace_exec;

  localparam int CTM_EV_TYPE_W = 2;

  typedef enum logic [CTM_EV_TYPE_W-1:0] {
    CTM_EV_CALL     = 2'd0,
    CTM_EV_RET      = 2'd1,
    CTM_EV_OVERFLOW = 2'd2
  } ctm_ev_type_t;

  typedef struct packed {
    ctm_ev_type_t ev_type;
    logic [31:0]  pc;
    logic [31:0]  target;
    logic [31:0]  timestamp;
  } ctm_event_t;

  // Jumps that link are calls; register jumps without link are returns.
  function automatic ctm_ev_type_t ctm_jump_type(input logic jal);
    return jal ? CTM_EV_CALL : CTM_EV_RET;
  endfunction

endpackage

// File: rtl/osd_ctm_event_fifo.sv
// Small ctm_event_t FIFO; accepts a push while full when a pop happens in the
// same cycle. The head is presented as zero while the FIFO is empty.
module osd_ctm_event_fifo
  import opensocdebug::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  ctm_event_t din,
  input  logic       pop,
  output ctm_event_t dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ctm_event_t      mem_q [DEPTH];
  ctm_event_t      mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked until an entry is written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/osd_ctm_mor1kx_events.sv
// Turns mor1kx retired jumps into a CALL/RET/OVERFLOW event stream.
// Optional capture timestamps are enabled with OSD_CTM_TIMESTAMP_EN.
module osd_ctm_mor1kx_events
  import opensocdebug::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int OVF_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  mor1kx_trace_exec trace_port,
  input  logic             enable,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [1:0]       ev_type,
  output logic [31:0]      ev_pc,
  output logic [31:0]      ev_target,
  output logic [31:0]      ev_time,
  output logic             ovf_pending
);

  logic [OVF_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [OVF_W:0]   ovf_sum;
  logic [OVF_W-1:0] ovf_rec_cnt;
  logic             ev_new, pop, room, push;
  logic             fifo_full, fifo_empty;
  ctm_event_t       rec, head;
  logic [31:0]      cur_time;

  assign ev_new = enable && trace_port.valid && trace_port.jb &&
                  (trace_port.jal || trace_port.jr);
  assign pop    = ev_valid && ev_ready;
  assign room   = !fifo_full || pop;

  // A jump dropped in the same cycle the overflow record goes out is folded in.
  assign ovf_sum     = {1'b0, ovf_cnt_q} + (OVF_W+1)'(ev_new);
  assign ovf_rec_cnt = ovf_sum[OVF_W] ? '1 : ovf_sum[OVF_W-1:0];

`ifdef OSD_CTM_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d;

  assign ts_d     = ts_q + 32'd1;
  assign cur_time = ts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end
`else
  assign cur_time = '0;
`endif

  always_comb begin
    rec       = '0;
    push      = 1'b0;
    ovf_cnt_d = ovf_cnt_q;
    if ((ovf_cnt_q != '0) && room) begin
      push          = 1'b1;
      rec.ev_type   = CTM_EV_OVERFLOW;
      rec.target    = 32'(ovf_rec_cnt);
      rec.timestamp = cur_time;
      ovf_cnt_d     = '0;
    end else if (ev_new && room) begin
      push          = 1'b1;
      rec.ev_type   = ctm_jump_type(trace_port.jal);
      rec.pc        = trace_port.pc;
      rec.target    = trace_port.jbtarget;
      rec.timestamp = cur_time;
    end else if (ev_new && (ovf_cnt_q != '1)) begin
      ovf_cnt_d = ovf_cnt_q + OVF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  osd_ctm_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (rec),
    .pop  (pop),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign ev_valid    = !fifo_empty;
  assign ev_type     = head.ev_type;
  assign ev_pc       = head.pc;
  assign ev_target   = head.target;
  assign ev_time     = head.timestamp;
  assign ovf_pending = (ovf_cnt_q != '0);

endmodule

// File: tb/tb_osd_ctm_mor1kx_events.sv
// Directed bench for the CTM event stream: call/return, filtering, overflow,
// backpressure, reset and capture timestamps.
module tb_osd_ctm_mor1kx_events;
  import opensocdebug::*;

  logic             clk;
  logic             rst;
  mor1kx_trace_exec trace;
  logic             enable;
  logic             ev_valid;
  logic             ev_ready;
  logic [1:0]       ev_type;
  logic [31:0]      ev_pc;
  logic [31:0]      ev_target;
  logic [31:0]      ev_time;
  logic             ovf_pending;

  int n_checks = 0;
  int n_pass   = 0;

  osd_ctm_mor1kx_events #(
    .FIFO_DEPTH(4),
    .OVF_W     (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trace_port (trace),
    .enable     (enable),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_type    (ev_type),
    .ev_pc      (ev_pc),
    .ev_target  (ev_target),
    .ev_time    (ev_time),
    .ovf_pending(ovf_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_trace(input logic v, input logic jb, input logic jal, input logic jr,
                           input logic [31:0] pc, input logic [31:0] tgt);
    trace.valid    = v;
    trace.jb       = jb;
    trace.jal      = jal;
    trace.jr       = jr;
    trace.pc       = pc;
    trace.jbtarget = tgt;
  endtask

  task automatic idle();
    set_trace(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic chk_ev(input string tag, input logic [1:0] t, input logic [31:0] pc,
                        input logic [31:0] tgt);
    chk({tag, ".valid"},  {63'h0, ev_valid}, 64'h1);
    chk({tag, ".type"},   {62'h0, ev_type}, {62'h0, t});
    chk({tag, ".pc"},     {32'h0, ev_pc}, {32'h0, pc});
    chk({tag, ".target"}, {32'h0, ev_target}, {32'h0, tgt});
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    ev_ready = 1'b0;
    idle();
    step();
    step();
    chk("rst.valid",  {63'h0, ev_valid}, 64'h0);
    chk("rst.type",   {62'h0, ev_type}, 64'h0);
    chk("rst.pc",     {32'h0, ev_pc}, 64'h0);
    chk("rst.target", {32'h0, ev_target}, 64'h0);
    chk("rst.time",   {32'h0, ev_time}, 64'h0);
    chk("rst.ovf",    {63'h0, ovf_pending}, 64'h0);
    rst = 1'b0;

    // Call then return, each visible one cycle after capture.
    enable = 1'b1;
    ev_ready = 1'b1;
    set_trace(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h400);
    step();
    chk_ev("call", 2'd0, 32'h100, 32'h400);
    set_trace(1'b1, 1'b1, 1'b0, 1'b1, 32'h420, 32'h104);
    step();
    chk_ev("ret", 2'd1, 32'h420, 32'h104);
    idle();
    step();
    chk("cr.drained", {63'h0, ev_valid}, 64'h0);

    // Filtering: plain jb, non-jb with jal, capture disabled.
    set_trace(1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h300);
    step();
    chk("filt.branch", {63'h0, ev_valid}, 64'h0);
    set_trace(1'b1, 1'b0, 1'b1, 1'b0, 32'h204, 32'h300);
    step();
    chk("filt.nonjb", {63'h0, ev_valid}, 64'h0);
    enable = 1'b0;
    set_trace(1'b1, 1'b1, 1'b1, 1'b0, 32'h208, 32'h300);
    step();
    chk("filt.disabled", {63'h0, ev_valid}, 64'h0);
    enable = 1'b1;
    idle();
    step();
    chk("filt.after", {63'h0, ev_valid}, 64'h0);

    // Overflow: 7 calls into a 4-deep FIFO with the sink stalled.
    ev_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_trace(1'b1, 1'b1, 1'b1, 1'b0, 32'h200 + 32'(4 * i), 32'h800);
      step();
    end
    idle();
    chk("ovf.pending", {63'h0, ovf_pending}, 64'h1);
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_ev($sformatf("ovf.call%0d", i), 2'd0, 32'h200 + 32'(4 * i), 32'h800);
      step();
      if (i == 0) chk("ovf.cleared", {63'h0, ovf_pending}, 64'h0);
    end
    chk_ev("ovf.rec", 2'd2, 32'h0, 32'h3);
    step();
    chk("ovf.empty", {63'h0, ev_valid}, 64'h0);

    // Drop and overflow insertion in the same cycle.
    ev_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_trace(1'b1, 1'b1, 1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'h900);
      step();
    end
    chk_ev("sim.head", 2'd0, 32'h300, 32'h900);
    ev_ready = 1'b1;
    set_trace(1'b1, 1'b1, 1'b1, 1'b0, 32'h3F0, 32'h900);
    step();
    idle();
    for (int i = 1; i < 4; i++) begin
      chk_ev($sformatf("sim.call%0d", i), 2'd0, 32'h300 + 32'(4 * i), 32'h900);
      step();
    end
    chk_ev("sim.rec", 2'd2, 32'h0, 32'h3);
    step();
    chk("sim.empty", {63'h0, ev_valid}, 64'h0);

    // Backpressure: fields hold while stalled.
    ev_ready = 1'b0;
    set_trace(1'b1, 1'b1, 1'b1, 1'b0, 32'h500, 32'hA00);
    step();
    set_trace(1'b1, 1'b1, 1'b0, 1'b1, 32'h504, 32'hA04);
    step();
    set_trace(1'b1, 1'b1, 1'b1, 1'b0, 32'h508, 32'hA08);
    step();
    idle();
    for (int k = 0; k < 3; k++) begin
      logic [1:0] t;
      t = (k == 1) ? 2'd1 : 2'd0;
      ev_ready = 1'b0;
      step();
      chk_ev($sformatf("bp.stall%0d", k), t, 32'h500 + 32'(4 * k), 32'hA00 + 32'(4 * k));
      ev_ready = 1'b1;
      chk_ev($sformatf("bp.take%0d", k), t, 32'h500 + 32'(4 * k), 32'hA00 + 32'(4 * k));
      step();
    end
    chk("bp.empty", {63'h0, ev_valid}, 64'h0);

    // Reset with three entries queued.
    ev_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_trace(1'b1, 1'b1, 1'b1, 1'b0, 32'h600 + 32'(4 * i), 32'hB00);
      step();
    end
    idle();
    chk("pre_rst.valid", {63'h0, ev_valid}, 64'h1);
    rst = 1'b1;
    step();
    chk("rst2.valid",  {63'h0, ev_valid}, 64'h0);
    chk("rst2.type",   {62'h0, ev_type}, 64'h0);
    chk("rst2.pc",     {32'h0, ev_pc}, 64'h0);
    chk("rst2.target", {32'h0, ev_target}, 64'h0);
    chk("rst2.time",   {32'h0, ev_time}, 64'h0);
    rst = 1'b0;

    // Capture timestamp: call issued in the 11th cycle after reset release.
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) chk("rst2.stays_empty", {63'h0, ev_valid}, 64'h0);
    end
    set_trace(1'b1, 1'b1, 1'b1, 1'b0, 32'h700, 32'hC00);
    step();
    idle();
    chk_ev("ts.call", 2'd0, 32'h700, 32'hC00);
`ifdef OSD_CTM_TIMESTAMP_EN
    chk("ts.time", {32'h0, ev_time}, 64'd10);
`else
    chk("ts.time", {32'h0, ev_time}, 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
